// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants and types for the seven-segment scanner
package seg_scan_pkg;

  localparam int N_DIGITS = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF = 8'hFF;

  typedef logic [7:0] seg_t;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [7:0] an_sel(input logic [2:0] i);
    return ~(8'b0000_0001 << i);
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - digit pattern inputs and scanned display outputs
interface seg_scan_if;
  import seg_scan_pkg::*;

  seg_t       seg0;
  seg_t       seg1;
  seg_t       seg2;
  seg_t       seg3;
  seg_t       seg4;
  seg_t       seg5;
  seg_t       seg6;
  seg_t       seg7;
  logic [7:0] en;
  logic [7:0] an;
  seg_t       seg;
  logic       frame;

  // Pattern source (debug unit side).
  modport master (
    output seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, en,
    input  an, seg, frame
  );

  // Scanner side.
  modport slave (
    input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, en,
    output an, seg, frame
  );

endinterface

// File: rtl/seg_scan_prescaler.sv
// rtl/seg_scan_prescaler.sv - slot cycle counter with end-of-slot strobe
module scan_prescaler #(
  parameter int DIV = 100000,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  assign wrap = (cnt == CW'(DIV - 1));

  // Count 0..DIV-1 and restart at the end of every slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - 8-digit time-multiplexed seven-segment scanner with frame snapshot
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic     clk,
  input  logic     rst,
  seg_scan_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;
  logic [2:0]    idx;
  logic          frame_edge;
  logic          in_blank;
  logic          lit;
  seg_t          live [N_DIGITS];
  seg_t          snap [N_DIGITS];
  logic [7:0]    snap_en;
  logic [7:0]    an_q;
  seg_t          seg_q;
  logic          frame_q;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (wrap)
  );

  assign live[0] = bus.seg0;
  assign live[1] = bus.seg1;
  assign live[2] = bus.seg2;
  assign live[3] = bus.seg3;
  assign live[4] = bus.seg4;
  assign live[5] = bus.seg5;
  assign live[6] = bus.seg6;
  assign live[7] = bus.seg7;

  // Last cycle of the last digit slot: the frame boundary.
  assign frame_edge = wrap && (idx == 3'(N_DIGITS - 1));

  // With no blanking the comparison would be constant, so drop it entirely.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK));
    end
  endgenerate

  assign lit = !in_blank && snap_en[idx];

  // Digit index advances once per slot and wraps 7 -> 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= 3'd0;
    end else if (wrap) begin
      idx <= idx + 3'd1;
    end
  end

  // Capture all patterns and the enable mask together so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        snap[i] <= SEG_OFF;
      end
      snap_en <= 8'h00;
    end else if (frame_edge) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        snap[i] <= live[i];
      end
      snap_en <= bus.en;
    end
  end

  // Registered drive of the shared anode/cathode lines from the pre-edge state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      frame_q <= 1'b0;
    end else begin
      an_q    <= lit ? an_sel(idx) : AN_OFF;
      seg_q   <= lit ? snap[idx] : SEG_OFF;
      frame_q <= frame_edge;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan
module tb_seg_scan;
  import seg_scan_pkg::*;

  localparam int DIV = 8;
  localparam int BLK = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  seg_t       drv [8];
  logic [7:0] drv_en;

  seg_scan_if bus0 ();
  seg_scan_if bus1 ();

  assign bus0.seg0 = drv[0];
  assign bus0.seg1 = drv[1];
  assign bus0.seg2 = drv[2];
  assign bus0.seg3 = drv[3];
  assign bus0.seg4 = drv[4];
  assign bus0.seg5 = drv[5];
  assign bus0.seg6 = drv[6];
  assign bus0.seg7 = drv[7];
  assign bus0.en   = drv_en;
  assign bus1.seg0 = drv[0];
  assign bus1.seg1 = drv[1];
  assign bus1.seg2 = drv[2];
  assign bus1.seg3 = drv[3];
  assign bus1.seg4 = drv[4];
  assign bus1.seg5 = drv[5];
  assign bus1.seg6 = drv[6];
  assign bus1.seg7 = drv[7];
  assign bus1.en   = drv_en;

  seg_scan #(.DIV(DIV), .BLANK(BLK)) dut (.clk(clk), .rst(rst), .bus(bus0));
  seg_scan #(.DIV(DIV), .BLANK(0))   dut0 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference: edge number since release gives slot position and digit directly.
  int         k = 0;
  seg_t       msnap [8];
  logic [7:0] men = 8'h00;
  logic [7:0] e_an = 8'hFF, e_seg = 8'hFF, e_an0 = 8'hFF, e_seg0 = 8'hFF;
  logic       e_frame = 1'b0;

  initial for (int i = 0; i < 8; i++) msnap[i] = 8'hFF;

  function automatic logic [7:0] m_an(input int kk, input int blank);
    int c = kk % DIV;
    int d = (kk / DIV) % 8;
    if (c >= blank && men[d]) return ~(8'd1 << d);
    return 8'hFF;
  endfunction

  function automatic logic [7:0] m_seg(input int kk, input int blank);
    int c = kk % DIV;
    int d = (kk / DIV) % 8;
    if (c >= blank && men[d]) return msnap[d];
    return 8'hFF;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k       <= 0;
      men     <= 8'h00;
      e_an    <= 8'hFF;
      e_seg   <= 8'hFF;
      e_an0   <= 8'hFF;
      e_seg0  <= 8'hFF;
      e_frame <= 1'b0;
      for (int i = 0; i < 8; i++) msnap[i] <= 8'hFF;
    end else begin
      k       <= k + 1;
      e_an    <= m_an(k, BLK);
      e_seg   <= m_seg(k, BLK);
      e_an0   <= m_an(k, 0);
      e_seg0  <= m_seg(k, 0);
      e_frame <= ((k % (8 * DIV)) == 8 * DIV - 1);
      if ((k % (8 * DIV)) == 8 * DIV - 1) begin
        for (int i = 0; i < 8; i++) msnap[i] <= drv[i];
        men <= drv_en;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_an", bus0.an, e_an);
      chk("mon_seg", bus0.seg, e_seg);
      chk("mon_frame", {7'd0, bus0.frame}, {7'd0, e_frame});
      chk("mon_an_b0", bus1.an, e_an0);
      chk("mon_seg_b0", bus1.seg, e_seg0);
      chk("mon_frame_b0", {7'd0, bus1.frame}, {7'd0, e_frame});
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!bus0.frame && n < 200);
    if (!bus0.frame) begin
      checks++;
      errors++;
      $display("FAIL wait_frame timeout act=none exp=pulse");
    end
  endtask

  // Release reset and confirm the first pulse lands on edge 64 with a dark frame.
  task automatic release_and_first_frame();
    int n = 0;
    bit lit_seen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bus0.an !== 8'hFF || bus0.seg !== 8'hFF || bus1.an !== 8'hFF) lit_seen = 1'b1;
    end while (!bus0.frame && n < 200);
    chk("first_frame_edge", 8'(n), 8'd64);
    chk("first_frame_dark", {7'd0, lit_seen}, 8'd0);
  endtask

  typedef struct {
    logic [7:0] en;
    int         digit;
    int         cyc;
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
  } vec_t;

  vec_t vecs [10];

  task automatic load_pattern();
    drv[0] = 8'hC0; drv[1] = 8'hF9; drv[2] = 8'hA4; drv[3] = 8'hB0;
    drv[4] = 8'h99; drv[5] = 8'h92; drv[6] = 8'h82; drv[7] = 8'hF8;
  endtask

  initial begin
    vecs[0] = '{8'hFF, 0, 4, 8'hFE, 8'hC0};
    vecs[1] = '{8'hFF, 0, 1, 8'hFF, 8'hFF};
    vecs[2] = '{8'hFF, 1, 2, 8'hFD, 8'hF9};
    vecs[3] = '{8'hFF, 3, 7, 8'hF7, 8'hB0};
    vecs[4] = '{8'hFF, 6, 0, 8'hFF, 8'hFF};
    vecs[5] = '{8'hFF, 7, 5, 8'h7F, 8'hF8};
    vecs[6] = '{8'h0F, 2, 4, 8'hFB, 8'hA4};
    vecs[7] = '{8'h0F, 4, 4, 8'hFF, 8'hFF};
    vecs[8] = '{8'h0F, 7, 7, 8'hFF, 8'hFF};
    vecs[9] = '{8'h80, 7, 3, 8'h7F, 8'hF8};

    load_pattern();
    drv_en = 8'hFF;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_an", bus0.an, 8'hFF);
    chk("reset_seg", bus0.seg, 8'hFF);
    chk("reset_frame", {7'd0, bus0.frame}, 8'd0);
    mon_on = 1'b1;
    release_and_first_frame();

    // Table: program en, let the next frame capture it, probe one slot position.
    for (int v = 0; v < 10; v++) begin
      drv_en = vecs[v].en;
      wait_frame();
      repeat (vecs[v].digit * DIV + vecs[v].cyc + 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_an", v), bus0.an, vecs[v].exp_an);
      chk($sformatf("vec%0d_seg", v), bus0.seg, vecs[v].exp_seg);
    end

    // Tear-free: change digit 3 during slot 1 of a frame already captured.
    drv_en = 8'hFF;
    wait_frame();
    wait_frame();
    repeat (DIV + 3) @(posedge clk);
    @(negedge clk);
    drv[3] = 8'h80;
    repeat (3 * DIV + 4 + 1 - (DIV + 3 + 1)) @(posedge clk);
    @(negedge clk);
    chk("tear_old_an", bus0.an, 8'hF7);
    chk("tear_old_seg", bus0.seg, 8'hB0);
    wait_frame();
    repeat (3 * DIV + 4 + 1) @(posedge clk);
    @(negedge clk);
    chk("tear_new_seg", bus0.seg, 8'h80);
    drv[3] = 8'hB0;

    // No-blank instance: digit 0 last cycle then digit 1 first cycle.
    wait_frame();
    wait_frame();
    repeat (DIV) @(posedge clk);
    @(negedge clk);
    chk("b0_last_d0", bus1.an, 8'hFE);
    @(posedge clk);
    @(negedge clk);
    chk("b0_first_d1", bus1.an, 8'hFD);
    chk("b0_first_d1_seg", bus1.seg, 8'hF9);

    // Asynchronous reset during a lit cycle of digit 5.
    wait_frame();
    repeat (5 * DIV + 4 + 1) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_an", bus0.an, 8'hDF);
    chk("pre_rst_seg", bus0.seg, 8'h92);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_an", bus0.an, 8'hFF);
    chk("async_rst_seg", bus0.seg, 8'hFF);
    chk("async_rst_an_b0", bus1.an, 8'hFF);
    repeat (2) @(negedge clk);
    release_and_first_frame();

    // Random pattern and mask traffic, checked by the reference every cycle.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) drv[$urandom_range(7)] = 8'($urandom);
      if ($urandom_range(63) == 0) drv_en = 8'($urandom);
    end

    @(negedge clk);
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
